// File: rtl/alu_mp_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// command encodings, FSM state type and first-word carry helpers.
package alu_mp_pkg;

    localparam logic [1:0] CMD_ADD = 2'd0;
    localparam logic [1:0] CMD_ADC = 2'd1;
    localparam logic [1:0] CMD_SUB = 2'd2;
    localparam logic [1:0] CMD_SBB = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Subtraction is a + ~b + carry, so SUB/SBB only differ from ADD/ADC in b inversion.
    function automatic logic cmd_is_sub(input logic [1:0] cmd);
        return (cmd == CMD_SUB) || (cmd == CMD_SBB);
    endfunction

    function automatic logic cmd_cin0(input logic [1:0] cmd, input logic cin);
        logic c;
        case (cmd)
            CMD_ADD: c = 1'b0;
            CMD_ADC: c = cin;
            CMD_SUB: c = 1'b1;
            default: c = cin;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu.sv
// Shared combinational N-bit ALU; also defines the ALU_* operation codes
// used by its initiators.
`ifndef ALU_OPS_DEFINED
`define ALU_OPS_DEFINED
`define ALU_ADD   3'd0
`define ALU_SUB   3'd1
`define ALU_AND   3'd2
`define ALU_OR    3'd3
`define ALU_XOR   3'd4
`define ALU_PASSB 3'd5
`endif

module alu #(
    parameter int N = 8
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] y,
    output logic         cout,
    output logic         ovf,
    output logic         zero,
    output logic         sign
);

    logic [N-1:0] bb;
    logic [N:0]   sum;

    // ALU_SUB is a + ~b + cin: cin=1 gives a plain subtract, cin=0 a borrow-in.
    always_comb begin
        bb   = (op == `ALU_SUB) ? ~b : b;
        sum  = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, cin};
        y    = '0;
        cout = 1'b0;
        ovf  = 1'b0;
        case (op)
            `ALU_ADD, `ALU_SUB: begin
                y    = sum[N-1:0];
                cout = sum[N];
                ovf  = (a[N-1] == bb[N-1]) && (sum[N-1] != a[N-1]);
            end
            `ALU_AND:   y = a & b;
            `ALU_OR:    y = a | b;
            `ALU_XOR:   y = a ^ b;
            `ALU_PASSB: y = b;
            default:    y = '0;
        endcase
    end

    assign zero = (y == '0);
    assign sign = y[N-1];

endmodule

// File: rtl/alu_mp_seq.sv
// Multi-precision add/subtract sequencer: drives one alu word per cycle, LSW first.
// Optional build macro ALU_MP_SEQ_ABORT_EN adds an `abort` input that cancels a RUN.
module alu_mp_seq
    import alu_mp_pkg::*;
#(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
`ifdef ALU_MP_SEQ_ABORT_EN
    input  logic               abort,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_cmd,
    input  logic               in_cin,
    input  logic [N*WORDS-1:0] in_a,
    input  logic [N*WORDS-1:0] in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] out_res,
    output logic               out_cout,
    output logic               out_ovf,
    output logic               out_sign,
    output logic               out_zero,
    output state_t             dbg_state
);

    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    // Handshakes: a transfer happens on a posedge where valid & ready are both 1.
    // in_ready is 1 only in IDLE; out_valid is 1 only in DONE and holds until out_ready.
    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q;
    logic            carry_q;
    logic            sub_q;
    logic [W-1:0]    a_q, b_q;
    logic [W-1:0]    work_q, work_d;
    logic            zero_acc_q;

    logic            accept;
    logic            last_word;
    logic            abort_req;

    logic [N-1:0]    alu_a, alu_b, alu_y;
    logic            alu_cout, alu_ovf, alu_zero, alu_sign;

`ifdef ALU_MP_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign accept    = in_valid && (state_q == IDLE);
    assign last_word = (idx_q == IW'(WORDS - 1));
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign dbg_state = state_q;

    assign alu_a = a_q[idx_q*N +: N];
    assign alu_b = sub_q ? ~b_q[idx_q*N +: N] : b_q[idx_q*N +: N];

    alu #(.N(N)) u_alu (
        .op   (`ALU_ADD),
        .a    (alu_a),
        .b    (alu_b),
        .cin  (carry_q),
        .y    (alu_y),
        .cout (alu_cout),
        .ovf  (alu_ovf),
        .zero (alu_zero),
        .sign (alu_sign)
    );

    always_comb begin
        work_d = work_q;
        work_d[idx_q*N +: N] = alu_y;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN: begin
                if (abort_req)      state_d = IDLE;
                else if (last_word) state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Words build up in work_q so the visible result only changes when an op completes;
    // an aborted op therefore leaves the previous result untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            carry_q    <= 1'b0;
            sub_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            work_q     <= '0;
            zero_acc_q <= 1'b0;
            out_res    <= '0;
            out_cout   <= 1'b0;
            out_ovf    <= 1'b0;
            out_sign   <= 1'b0;
            out_zero   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q        <= in_a;
                        b_q        <= in_b;
                        sub_q      <= cmd_is_sub(in_cmd);
                        carry_q    <= cmd_cin0(in_cmd, in_cin);
                        idx_q      <= '0;
                        work_q     <= '0;
                        zero_acc_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort_req) begin
                        idx_q <= '0;
                    end else begin
                        carry_q    <= alu_cout;
                        work_q     <= work_d;
                        zero_acc_q <= zero_acc_q & alu_zero;
                        if (last_word) begin
                            idx_q    <= '0;
                            out_res  <= work_d;
                            out_cout <= alu_cout;
                            out_ovf  <= alu_ovf;
                            out_sign <= alu_sign;
                            out_zero <= zero_acc_q & alu_zero;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
